// File: rtl/pwm_pkg.sv
// Shared definitions for the LED PWM path: sequencer phase codes and the
// clock/PWM rate constants used by the PWM stage.
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int CLK_FREQ   = 50_000_000;
  localparam int PWM_FREQ   = 20_000;
  localparam int PWM_PERIOD = CLK_FREQ / PWM_FREQ;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HIGH = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LOW  = 3'd4
  } phase_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter; tc_o flags a count of zero. Load has priority over
// decrement, and the count saturates at zero.
module tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Breathing-duty sequencer: ramps duty up/down in period-aligned steps with
// hold plateaus at both ends, counting completed breathe cycles.
//
//   state        | meaning
//   ST_IDLE      | duty forced to 0, waiting for enable at a period tick
//   ST_RAMP_UP   | duty += STEP every STEP_TICKS periods, saturating at MAX_DUTY
//   ST_HOLD_HIGH | duty held at MAX_DUTY for HOLD_TICKS periods
//   ST_RAMP_DOWN | duty -= STEP every STEP_TICKS periods, floored at 0
//   ST_HOLD_LOW  | duty held at 0 for HOLD_TICKS periods, then cycle count++
module pwm_fade_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int MAX_DUTY   = 255,
  parameter int STEP       = 4,
  parameter int STEP_TICKS = 2,
  parameter int HOLD_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              period_tick_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_upd_o,
  output logic [2:0]        phase_o,
  output logic [15:0]       cycles_o
);

  localparam int CNT_W = $clog2(max_int(STEP_TICKS, HOLD_TICKS)) + 1;
  localparam logic [CNT_W-1:0]  STEP_LOAD = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
  localparam logic [DUTY_W:0]   MAX_WIDE  = (DUTY_W + 1)'(MAX_DUTY);
  localparam logic [DUTY_W:0]   STEP_WIDE = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);

  phase_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              upd_q, upd_d;
  logic [15:0]       cycles_q, cycles_d;

  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W-1:0] down_val;
  logic              step_tc, hold_tc;
  logic              step_evt;
  logic              state_chg, in_idle;
  logic              step_load, hold_load;
  logic              step_dec, hold_dec;

  // Extra headroom bit keeps the saturating add from wrapping near 2^DUTY_W.
  assign up_sum   = {1'b0, duty_q} + STEP_WIDE;
  assign down_val = (duty_q < STEP_D) ? '0 : (duty_q - STEP_D);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    upd_d    = 1'b0;
    cycles_d = cycles_q;
    step_evt = 1'b0;

    // Disable overrides everything, including a step due on this same tick.
    if ((state_q != ST_IDLE) && !enable_i) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      upd_d   = (duty_q != '0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (enable_i && period_tick_i) begin
            state_d = ST_RAMP_UP;
          end
        end

        ST_RAMP_UP: begin
          if (period_tick_i && step_tc) begin
            step_evt = 1'b1;
            upd_d    = 1'b1;
            if (up_sum >= MAX_WIDE) begin
              duty_d  = MAX_D;
              state_d = ST_HOLD_HIGH;
            end else begin
              duty_d = up_sum[DUTY_W-1:0];
            end
          end
        end

        ST_HOLD_HIGH: begin
          if (period_tick_i && hold_tc) begin
            state_d = ST_RAMP_DOWN;
          end
        end

        ST_RAMP_DOWN: begin
          if (period_tick_i && step_tc) begin
            step_evt = 1'b1;
            upd_d    = 1'b1;
            duty_d   = down_val;
            if (down_val == '0) begin
              state_d = ST_HOLD_LOW;
            end
          end
        end

        ST_HOLD_LOW: begin
          if (period_tick_i && hold_tc) begin
            state_d  = ST_RAMP_UP;
            cycles_d = cycles_q + 16'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
          upd_d   = (duty_q != '0);
        end
      endcase
    end
  end

  // Counters are reloaded on every state change and after every step, so a
  // fresh N-1 preload means the N-th tick in the state hits terminal count.
  assign state_chg = (state_d != state_q);
  assign in_idle   = (state_q == ST_IDLE);
  assign step_load = state_chg | step_evt | in_idle;
  assign hold_load = state_chg | in_idle;
  assign step_dec  = period_tick_i & ~step_load;
  assign hold_dec  = period_tick_i & ~hold_load;

  tick_counter #(.W(CNT_W)) u_step_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (step_load),
    .load_val_i (STEP_LOAD),
    .dec_i      (step_dec),
    .tc_o       (step_tc)
  );

  tick_counter #(.W(CNT_W)) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hold_load),
    .load_val_i (HOLD_LOAD),
    .dec_i      (hold_dec),
    .tc_o       (hold_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      upd_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      upd_q    <= upd_d;
      cycles_q <= cycles_d;
    end
  end

  assign duty_o     = duty_q;
  assign duty_upd_o = upd_q;
  assign phase_o    = state_q;
  assign cycles_o   = cycles_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench: two sequencer instances (default and small-saturation
// parameters) compared cycle by cycle against a behavioural model.
module tb_pwm_fade_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, period_tick;

  logic [7:0]  duty_a, duty_b;
  logic        upd_a, upd_b;
  logic [2:0]  phase_a, phase_b;
  logic [15:0] cycles_a, cycles_b;

  pwm_fade_sequencer dut_a (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .period_tick_i (period_tick),
    .duty_o        (duty_a),
    .duty_upd_o    (upd_a),
    .phase_o       (phase_a),
    .cycles_o      (cycles_a)
  );

  pwm_fade_sequencer #(
    .DUTY_W(8), .MAX_DUTY(10), .STEP(4), .STEP_TICKS(1), .HOLD_TICKS(2)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .period_tick_i (period_tick),
    .duty_o        (duty_b),
    .duty_upd_o    (upd_b),
    .phase_o       (phase_b),
    .cycles_o      (cycles_b)
  );

  wire [27:0] obs_a = {duty_a, upd_a, phase_a, cycles_a};
  wire [27:0] obs_b = {duty_b, upd_b, phase_b, cycles_b};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase code, duty, tick count since last step/state entry.
  int m_ph[2], m_duty[2], m_upd[2], m_cnt[2], m_cyc[2];

  function automatic logic [27:0] exp_vec(input int k);
    return {8'(m_duty[k]), 1'(m_upd[k]), 3'(m_ph[k]), 16'(m_cyc[k])};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int mx, stp, st, ht;
      mx  = (k == 0) ? 255 : 10;
      stp = 4;
      st  = (k == 0) ? 2 : 1;
      ht  = (k == 0) ? 4 : 2;
      if (rst) begin
        m_ph[k] = 0; m_duty[k] = 0; m_upd[k] = 0; m_cnt[k] = 0; m_cyc[k] = 0;
      end else if (m_ph[k] != 0 && !enable) begin
        m_upd[k] = (m_duty[k] != 0) ? 1 : 0;
        m_ph[k] = 0; m_duty[k] = 0; m_cnt[k] = 0;
      end else begin
        m_upd[k] = 0;
        case (m_ph[k])
          0: begin
            m_cnt[k] = 0;
            if (enable && period_tick) m_ph[k] = 1;
          end
          1: if (period_tick) begin
            m_cnt[k]++;
            if (m_cnt[k] == st) begin
              m_cnt[k] = 0;
              m_duty[k] = (m_duty[k] + stp > mx) ? mx : m_duty[k] + stp;
              m_upd[k] = 1;
              if (m_duty[k] == mx) m_ph[k] = 2;
            end
          end
          2: if (period_tick) begin
            m_cnt[k]++;
            if (m_cnt[k] == ht) begin m_cnt[k] = 0; m_ph[k] = 3; end
          end
          3: if (period_tick) begin
            m_cnt[k]++;
            if (m_cnt[k] == st) begin
              m_cnt[k] = 0;
              m_duty[k] = (m_duty[k] < stp) ? 0 : m_duty[k] - stp;
              m_upd[k] = 1;
              if (m_duty[k] == 0) m_ph[k] = 4;
            end
          end
          default: if (period_tick) begin
            m_cnt[k]++;
            if (m_cnt[k] == ht) begin
              m_cnt[k] = 0; m_ph[k] = 1; m_cyc[k] = (m_cyc[k] + 1) % 65536;
            end
          end
        endcase
      end
    end
  endtask

  // One clock: apply inputs, advance model on the edge, return 1 ns later.
  task automatic tick_clk(input logic r, input logic en, input logic tk);
    rst = r; enable = en; period_tick = tk;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick_clk(1'b1, 1'b1, 1'(i % 2 == 0));
      n_total++;
      if (obs_a !== 28'h0) $display("FAIL reset_a cyc %0d: got %h, want 0", i, obs_a);
      else n_pass++;
      n_total++;
      if (obs_b !== 28'h0) $display("FAIL reset_b cyc %0d: got %h, want 0", i, obs_b);
      else n_pass++;
    end
    tick_clk(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ramp_up();
    int c = 0, nt = 0, nu = 0;
    logic [2:0] pre;
    while (m_ph[0] != 2 && c < 3000) begin
      logic tk;
      tk = 1'(c % 10 == 0);
      pre = phase_a;
      tick_clk(1'b0, 1'b1, tk);
      if (tk && pre == 3'd1) nt++;
      if (upd_a) nu++;
      n_total++;
      if (obs_a !== exp_vec(0)) $display("FAIL ramp_up_a c=%0d: got %h, want %h", c, obs_a, exp_vec(0));
      else n_pass++;
      n_total++;
      if (obs_b !== exp_vec(1)) $display("FAIL ramp_up_b c=%0d: got %h, want %h", c, obs_b, exp_vec(1));
      else n_pass++;
      c++;
    end
    n_total++;
    if (m_ph[0] != 2) $display("FAIL ramp_up_timeout: phase %0d, want 2", phase_a);
    else n_pass++;
    n_total++;
    if ({duty_a, upd_a, phase_a} !== {8'd255, 1'b1, 3'd2})
      $display("FAIL ramp_up_peak: got duty %0d upd %0d phase %0d, want 255 1 2", duty_a, upd_a, phase_a);
    else n_pass++;
    n_total++;
    if (nu != 64 || nt != 128) $display("FAIL ramp_up_counts: got %0d steps %0d ticks, want 64 128", nu, nt);
    else n_pass++;
  endtask

  task automatic test_full_cycle();
    int c = 0, nh = 0, nd = 0, first_down = -1, last_nz = -1;
    logic prev_upd = 1'b0;
    logic [2:0] pre;
    while (!(m_cyc[0] == 1 && m_ph[0] == 1) && c < 4000) begin
      logic tk;
      tk = 1'(c % 10 == 0);
      pre = phase_a;
      tick_clk(1'b0, 1'b1, tk);
      if (tk && pre == 3'd2) nh++;
      if (upd_a && phase_a inside {3'd3, 3'd4}) begin
        nd++;
        if (first_down < 0) first_down = duty_a;
        if (duty_a != 0) last_nz = duty_a;
      end
      n_total++;
      if (obs_a !== exp_vec(0) || (prev_upd && upd_a))
        $display("FAIL full_cycle_a c=%0d: got %h, want %h", c, obs_a, exp_vec(0));
      else n_pass++;
      prev_upd = upd_a;
      c++;
    end
    n_total++;
    if (nh != 4 || nd != 64 || first_down != 251 || last_nz != 3)
      $display("FAIL full_cycle_shape: got hold %0d down %0d first %0d last %0d, want 4 64 251 3",
               nh, nd, first_down, last_nz);
    else n_pass++;
    n_total++;
    if (cycles_a !== 16'd1 || phase_a !== 3'd1)
      $display("FAIL full_cycle_end: got cycles %0d phase %0d, want 1 1", cycles_a, phase_a);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int got[$];
    int exp_sat[6] = '{4, 8, 10, 6, 2, 0};
    int c = 0;
    tick_clk(1'b1, 1'b0, 1'b0);
    while (got.size() < 6 && c < 500) begin
      tick_clk(1'b0, 1'b1, 1'(c % 3 == 0));
      if (upd_b) got.push_back(int'(duty_b));
      n_total++;
      if (obs_b !== exp_vec(1)) $display("FAIL sat_b c=%0d: got %h, want %h", c, obs_b, exp_vec(1));
      else n_pass++;
      c++;
    end
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (i >= got.size() || got[i] != exp_sat[i])
        $display("FAIL sat_seq[%0d]: got %0d, want %0d", i, (i < got.size()) ? got[i] : -1, exp_sat[i]);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    int c = 0;
    tick_clk(1'b1, 1'b0, 1'b0);
    while (!(m_duty[0] == 100 && m_cnt[0] == 1) && c < 2000) begin
      tick_clk(1'b0, 1'b1, 1'(c % 4 == 0));
      c++;
    end
    tick_clk(1'b0, 1'b0, 1'b1);
    n_total++;
    if ({duty_a, upd_a, phase_a} !== {8'd0, 1'b1, 3'd0})
      $display("FAIL disable_step: got duty %0d upd %0d phase %0d, want 0 1 0", duty_a, upd_a, phase_a);
    else n_pass++;
    n_total++;
    if (obs_a !== exp_vec(0)) $display("FAIL disable_model: got %h, want %h", obs_a, exp_vec(0));
    else n_pass++;
    tick_clk(1'b0, 1'b0, 1'b0);
    n_total++;
    if (upd_a !== 1'b0) $display("FAIL disable_single_pulse: got upd %0d, want 0", upd_a);
    else n_pass++;
    c = 0;
    while (!upd_a && c < 100) begin
      tick_clk(1'b0, 1'b1, 1'(c % 4 == 0));
      c++;
    end
    n_total++;
    if (duty_a !== 8'd4 || phase_a !== 3'd1)
      $display("FAIL reenable_first: got duty %0d phase %0d, want 4 1", duty_a, phase_a);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tick_clk(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 19) != 0),
               1'($urandom_range(0, 3) == 0));
      n_total++;
      if (obs_a !== exp_vec(0)) $display("FAIL random_a c=%0d: got %h, want %h", c, obs_a, exp_vec(0));
      else n_pass++;
      n_total++;
      if (obs_b !== exp_vec(1)) $display("FAIL random_b c=%0d: got %h, want %h", c, obs_b, exp_vec(1));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int c = 0;
    tick_clk(1'b1, 1'b0, 1'b0);
    tick_clk(1'b0, 1'b1, 1'b1);
    force dut_a.cycles_q = 16'hFFFF;
    m_cyc[0] = 16'hFFFF;
    tick_clk(1'b0, 1'b1, 1'b0);
    release dut_a.cycles_q;
    while (!(m_cyc[0] == 0 && m_ph[0] == 1) && c < 2000) begin
      tick_clk(1'b0, 1'b1, 1'(c % 2 == 0));
      n_total++;
      if (obs_a !== exp_vec(0)) $display("FAIL wrap_a c=%0d: got %h, want %h", c, obs_a, exp_vec(0));
      else n_pass++;
      c++;
    end
    n_total++;
    if (cycles_a !== 16'h0000 || phase_a !== 3'd1)
      $display("FAIL wrap_end: got cycles %h phase %0d, want 0000 1", cycles_a, phase_a);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; period_tick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_duty[k] = 0; m_upd[k] = 0; m_cnt[k] = 0; m_cyc[k] = 0;
    end
    test_reset();
    test_ramp_up();
    test_full_cycle();
    test_saturation();
    test_disable();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
